// File: rtl/prog_loader_pkg.sv
// Shared LC2K program-loader definitions: loader FSM state encoding, frame
// constants and a small helper to classify byte-accepting states.
// Optional feature macro: LOADER_CHECKSUM_EN adds the trailing-checksum state.
package prog_loader_pkg;

  // Frame header is a 16-bit big-endian word count.
  localparam int unsigned HdrLenBytes  = 2;
  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned WordW        = 8 * BytesPerWord;
  localparam int unsigned ByteCntW     = $clog2(BytesPerWord);

  typedef enum logic [2:0] {
    StLenHi = 3'd0,
    StLenLo = 3'd1,
    StCheck = 3'd2,
    StWord  = 3'd3,
    StWrite = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    StChk   = 3'd5,
`endif
    StDone  = 3'd6,
    StErr   = 3'd7
  } state_e;

  // State entered once the last word (or an empty header) has been consumed.
`ifdef LOADER_CHECKSUM_EN
  localparam state_e StLoaded = StChk;
`else
  localparam state_e StLoaded = StDone;
`endif

  function automatic logic is_accepting(state_e s);
    logic acc;
    acc = (s == StLenHi) || (s == StLenLo) || (s == StWord);
`ifdef LOADER_CHECKSUM_EN
    acc = acc || (s == StChk);
`endif
    return acc;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles big-endian bytes into a 32-bit word.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clear_i       synchronous clear of the byte count
//   valid_i       a byte is being consumed this cycle
//   byte_i        byte data
//   word_o        assembled word (valid from the cycle after word_valid_o)
//   word_valid_o  pulse in the cycle the last byte of a word is consumed
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [7:0]       byte_i,
  output logic [WordW-1:0] word_o,
  output logic             word_valid_o
);

  logic [ByteCntW-1:0] cnt_q, cnt_d;
  logic [WordW-1:0]    shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (valid_i) begin
      // First byte ends up in bits 31:24 after four shifts.
      shift_d = {shift_q[WordW-9:0], byte_i};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  assign word_valid_o = valid_i && !clear_i && (cnt_q == ByteCntW'(BytesPerWord - 1));
  assign word_o       = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader for an LC2K CPU. Receives a frame (16-bit word
// count, then big-endian 32-bit words), writes each word to instruction
// memory and releases the CPU once the whole program is in place.
// Optional feature macro: LOADER_CHECKSUM_EN -- a trailing XOR checksum byte
// over all preceding frame bytes must match before the CPU is released.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   restart             synchronous abort-and-reload pulse
//   in_valid/in_data    byte stream in; consumed when in_valid && in_ready
//   in_ready            loader can take a byte
//   imem_we/addr/wdata  one-cycle instruction-memory write
//   cpu_run             program loaded successfully
//   load_err            sticky frame error (oversize or bad checksum)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_err
);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              load_err_q, load_err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic              accept;
  logic              pk_valid;
  logic [WordW-1:0]  pk_word;
  logic              pk_word_valid;

  // in_ready is the registered flag, so acceptance matches what the source sees.
  assign accept   = in_valid && in_ready_q && !restart;
  assign pk_valid = accept && (state_q == StWord);

  byte_packer u_byte_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (restart),
    .valid_i      (pk_valid),
    .byte_i       (in_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d        = chk_q;
`endif

    if (restart) begin
      state_d = StLenHi;
      len_d   = '0;
      idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
      chk_d   = '0;
`endif
    end else begin
`ifdef LOADER_CHECKSUM_EN
      if (accept && (state_q != StChk)) begin
        chk_d = chk_q ^ in_data;
      end
`endif
      unique case (state_q)
        StLenHi: begin
          if (accept) begin
            len_d[15:8] = in_data;
            state_d     = StLenLo;
          end
        end
        StLenLo: begin
          if (accept) begin
            len_d[7:0] = in_data;
            state_d    = StCheck;
          end
        end
        StCheck: begin
          if (32'(len_q) > MAX_WORDS) begin
            state_d = StErr;
          end else if (len_q == 16'd0) begin
            state_d = StLoaded;
          end else begin
            state_d = StWord;
          end
        end
        StWord: begin
          if (pk_word_valid) begin
            state_d = StWrite;
          end
        end
        StWrite: begin
          // Strobe is registered, so a restart here still cancels this write.
          imem_we_d    = 1'b1;
          imem_addr_d  = ADDR_W'(idx_q);
          imem_wdata_d = pk_word;
          if (idx_q == len_q - 16'd1) begin
            state_d = StLoaded;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = StWord;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StChk: begin
          if (accept) begin
            state_d = (in_data == chk_q) ? StDone : StErr;
          end
        end
`endif
        StDone: state_d = StDone;
        StErr:  state_d = StErr;
        default: state_d = StErr;
      endcase
    end

    in_ready_d = is_accepting(state_d);
    cpu_run_d  = (state_d == StDone);
    load_err_d = (state_d == StErr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StLenHi;
      len_q        <= '0;
      idx_q        <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_run_q    <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_run_q    <= cpu_run_d;
      load_err_q   <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign load_err   = load_err_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_WORDS, default 256: largest accepted program length in words; must be ≤ 2**ADDR_W.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port restart  input  1: synchronous pulse that aborts any load and begins a new one.
REQ-006 SHALL have port in_valid  input  1: byte-stream valid.
REQ-007 SHALL have port in_data  input  8: byte-stream data.
REQ-008 SHALL have port in_ready  output  1: loader accepts a byte when in_valid && in_ready.
REQ-009 SHALL have port imem_we  output  1: one-cycle write strobe to instruction memory.
REQ-010 SHALL have port imem_addr  output  ADDR_W: word address of the write.
REQ-011 SHALL have port imem_wdata  output  32: LC2K instruction word to write.
REQ-012 SHALL have port cpu_run  output  1: releases the CPU; high only after a successful load.
REQ-013 SHALL have port load_err  output  1: sticky error flag.

Function
REQ-014 SHALL accept a frame: LEN_HI byte, LEN_LO byte (16-bit word count N, big-endian), then N words of 4 bytes each, big-endian (first byte is bits 31:24).
REQ-015 SHALL implement states LEN_HI, LEN_LO, CHECK, WORD, WRITE, CHK, DONE, ERR; CHK exists only per REQ-027.
REQ-016 SHALL drive in_ready=1 in LEN_HI, LEN_LO, WORD and CHK, and in_ready=0 in CHECK, WRITE, DONE and ERR.
REQ-017 SHALL go from LEN_LO to CHECK; CHECK lasts one cycle and then goes to ERR if N > MAX_WORDS, to DONE (or CHK) if N == 0, else to WORD.
REQ-018 SHALL go from WORD to WRITE in the cycle after the 4th byte of a word is accepted; WRITE asserts imem_we for exactly one cycle with imem_addr = word index (0-based) and imem_wdata = the assembled word.
REQ-019 SHALL leave WRITE for WORD if index < N-1 (index then increments), else for DONE (or CHK); the word index wraps never, because N ≤ MAX_WORDS.
REQ-020 SHALL assert cpu_run continuously from the first DONE cycle until reset or restart.
REQ-021 SHALL set load_err and hold it in ERR until reset or restart; cpu_run stays 0 in ERR.
REQ-022 SHALL stall on in_valid=0 in any accepting state with no state or byte-count change.
REQ-023 SHALL on restart=1, regardless of state (including during WRITE), next cycle enter LEN_HI with cpu_run=0, load_err=0, imem_we=0, and byte/word counters cleared; a byte presented in the restart cycle is not accepted.
REQ-024 SHALL register all outputs; imem_addr and imem_wdata hold their last values when imem_we=0.

Reset
REQ-025 SHALL on rst_n=0 asynchronously enter LEN_HI and clear in_ready-related state, imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, load_err=0, all counters=0; in_ready=1 from the first clock edge after rst_n returns high.

Configuration
REQ-026 SHALL compile the checksum feature only when LOADER_CHECKSUM_EN is defined.
REQ-027 SHALL with LOADER_CHECKSUM_EN defined, expect one trailing byte after the last word (or after LEN_LO when N == 0) in state CHK. That byte equals the XOR of all preceding frame bytes, including the length bytes. A match goes to DONE; a mismatch goes to ERR.
REQ-028 SHALL without LOADER_CHECKSUM_EN, omit the CHK state and the XOR register and go directly to DONE.

Structure
REQ-029 SHALL place the state enum, the frame header length (2) and the bytes-per-word (4) constants in the shared lc2k package.
REQ-030 SHALL use one sub-module, byte_packer: a shift register plus a 2-bit count that assembles 4 bytes into a 32-bit word and emits a word_valid pulse.

Verification
REQ-031 SHALL cover: stream 00 02 | 00810002 | 01C00000 with valid held high -> imem_we at addr 0 = 0x00810002 and at addr 1 = 0x01C00000; cpu_run=1 after the second write.
REQ-032 SHALL cover: frame 00 00 -> no imem_we; cpu_run=1 two cycles after LEN_LO is accepted.
REQ-033 SHALL cover: frame 01 01 (N=257) with MAX_WORDS=256 -> load_err=1, in_ready=0, cpu_run=0, no writes.
REQ-034 SHALL cover: valid toggling every other cycle on the 1-word frame 00 01 12345678 -> single write of 0x12345678 to addr 0.
REQ-035 SHALL cover: restart asserted during the WRITE of word 1 of a 3-word frame -> that write is suppressed, LEN_HI next cycle, and a fresh 1-word frame then loads correctly.
REQ-036 SHALL cover, with LOADER_CHECKSUM_EN defined: frame 00 01 00000005 04 -> cpu_run=1; the same frame with checksum 05 -> load_err=1.
